// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM state encoding
// and a constant-evaluable ceil(log2) used to size index ports.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is duplicated to
// double width, everything below ptr is masked off, and the lowest
// remaining set bit wins; folding both halves gives the wrapped grant.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // Mask requests below ptr, isolate the lowest survivor, fold to N bits.
  always_comb begin
    dbl        = {req, req};
    mask       = ~(((2*N)'(1) << ptr) - (2*N)'(1));
    masked     = dbl & mask;
    lowest     = masked & (~masked + (2*N)'(1));
    gnt_onehot = lowest[N-1:0] | lowest[2*N-1:N];
    any        = |req;
  end

  // Encode the one-hot grant into an index (zero when nothing is pending).
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_onehot[i]) begin
        gnt_idx = PW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO between NUM_REQ requesters.
// Each requester has a one-entry holding register; the FSM issues one
// word as a single-cycle write pulse, then idles GAP_CYCLES cycles so the
// FIFO's registered prog_full flag has settled before the next decision.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int REG_WIDTH  = 32,
  parameter int GAP_CYCLES = 2,
  parameter int ID_W       = clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_WIDTH-1:0] req_reg,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         tx_ready,
  output logic                         tx_valid,
  output logic [REG_WIDTH-1:0]         tx_reg,
  output logic [ID_W-1:0]              tx_id,
  output logic                         busy
);

  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [REG_WIDTH-1:0]   tx_reg_q, tx_reg_d;
  logic [ID_W-1:0]        tx_id_q, tx_id_d;

  logic [REG_WIDTH-1:0]   hold_q [NUM_REQ];
  logic [NUM_REQ-1:0]     hold_valid_q, hold_valid_d;
  logic [NUM_REQ-1:0]     hold_load;
  logic [NUM_REQ-1:0]     hold_clr;

  logic [NUM_REQ-1:0]     pick_onehot;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic                   grant_en;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rr_pick (
    .req        (hold_valid_q),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // A slot loads only while empty and clears only when granted; a granted
  // slot is full, so load and clear never hit the same bit together.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold
    assign hold_load[gi] = req_valid[gi] & ~hold_valid_q[gi];
    assign hold_clr[gi]  = grant_en & pick_onehot[gi];
  end

  // Next occupancy of the holding registers.
  always_comb begin
    hold_valid_d = (hold_valid_q | hold_load) & ~hold_clr;
  end

  // Holding registers: occupancy flags and captured words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hold_load[i]) begin
          hold_q[i] <= req_reg[i*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
  end

  // FSM next state: grant in IDLE, one-cycle ISSUE, then a counted GAP.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    tx_reg_d  = tx_reg_q;
    tx_id_d   = tx_id_q;
    grant_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && pick_any) begin
          grant_en = 1'b1;
          tx_reg_d = hold_q[pick_idx];
          tx_id_d  = pick_idx;
          rr_ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The grant is already committed; a late tx_ready drop is
        // absorbed by FIFO headroom, so the pulse is unconditional.
        gap_cnt_d = '0;
        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    tx_valid_d = (state_d == ISSUE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_reg_q   <= '0;
      tx_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_reg_q   <= tx_reg_d;
      tx_id_q    <= tx_id_d;
    end
  end

  assign req_ready = ~hold_valid_q;
  assign busy      = (state_q != IDLE) || (|hold_valid_q);
  assign tx_valid  = tx_valid_q;
  assign tx_reg    = tx_reg_q;
  assign tx_id     = tx_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// slot/queue-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int RW   = 32;
  localparam int GAP  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*RW-1:0] req_reg = '0;
  logic [NREQ-1:0]    req_ready;
  logic               tx_ready = 1'b1;
  logic               tx_valid;
  logic [RW-1:0]      tx_reg;
  logic [1:0]         tx_id;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  uart_tx_arbiter #(
    .NUM_REQ    (NREQ),
    .REG_WIDTH  (RW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_ready (req_ready),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_reg    (tx_reg),
    .tx_id     (tx_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots are full/empty flags; a grant may happen at cycle k when
  // k >= next_grant, and the pulse appears in cycle k+1. After a grant the
  // next decision is possible at k + 2 + GAP.
  logic [NREQ-1:0] m_hold_v;
  logic [RW-1:0]   m_hold [NREQ];
  int              m_ptr;
  int              m_cyc;
  int              m_next_grant;
  logic            m_tx_valid;
  logic [RW-1:0]   m_tx_reg;
  logic [1:0]      m_tx_id;
  logic [NREQ-1:0] m_ready;
  logic            m_busy;

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int j = 0; j < NREQ; j++) begin
      int idx;
      idx = (ptr + j) % NREQ;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  assign m_ready = ~m_hold_v;
  assign m_busy  = (|m_hold_v) || (m_cyc < m_next_grant);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold_v     <= '0;
      m_ptr        <= 0;
      m_cyc        <= 0;
      m_next_grant <= 0;
      m_tx_valid   <= 1'b0;
      m_tx_reg     <= '0;
      m_tx_id      <= '0;
    end else begin
      m_cyc      <= m_cyc + 1;
      m_tx_valid <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !m_hold_v[i]) begin
          m_hold_v[i] <= 1'b1;
          m_hold[i]   <= req_reg[i*RW +: RW];
        end
      end
      if (tx_ready && (|m_hold_v) && (m_cyc >= m_next_grant)) begin
        m_tx_valid                     <= 1'b1;
        m_tx_id                        <= 2'(pick(m_hold_v, m_ptr));
        m_tx_reg                       <= m_hold[pick(m_hold_v, m_ptr)];
        m_hold_v[pick(m_hold_v, m_ptr)] <= 1'b0;
        m_ptr                          <= (pick(m_hold_v, m_ptr) + 1) % NREQ;
        m_next_grant                   <= m_cyc + 2 + GAP;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_tx_valid", tx_valid, m_tx_valid);
      chk("cmp_req_ready", req_ready, m_ready);
      chk("cmp_busy", busy, m_busy);
      chk("cmp_tx_id", tx_id, m_tx_id);
      chk("cmp_tx_reg", tx_reg, m_tx_reg);
    end
  end

  // ---------------- stimulus helpers ----------------
  int p_n;
  int p_id  [16];
  int p_cyc [16];
  logic [RW-1:0] p_reg [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present words for one cycle on the selected requesters.
  task automatic load(input logic [NREQ-1:0] mask, input logic [RW-1:0] base);
    for (int i = 0; i < NREQ; i++) begin
      req_reg[i*RW +: RW] = base + RW'(i);
    end
    req_valid = mask;
    tick();
    req_valid = '0;
  endtask

  // Record every pulse over a bounded window.
  task automatic collect(input int ncyc);
    p_n = 0;
    repeat (ncyc) begin
      tick();
      if (tx_valid) begin
        if (p_n < 16) begin
          p_id[p_n]  = int'(tx_id);
          p_cyc[p_n] = cyc;
          p_reg[p_n] = tx_reg;
        end
        p_n++;
      end
    end
  endtask

  int pulses;
  bit found;

  initial begin
    // 1 Reset state and quiet idle
    #23;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_req_ready", req_ready, 4'b1111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_reg", tx_reg, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      tick();
      chk("idle_no_pulse", tx_valid, 1'b0);
    end

    // 3 Fairness: all four pending, rotation 0,1,2,3 every 2+GAP cycles
    tick();
    load(4'b1111, 32'hA000_0000);
    collect(24);
    chk("fair_count", p_n, 4);
    for (int k = 0; k < 4; k++) begin
      chk("fair_id", p_id[k], k);
      chk("fair_reg", p_reg[k], 32'hA000_0000 + k);
      if (k > 0) chk("fair_spacing", p_cyc[k] - p_cyc[k-1], 2 + GAP);
    end

    // 4 Backpressure on requesters 1 and 3
    tx_ready = 1'b0;
    tick();
    load(4'b1010, 32'hB000_0000);
    repeat (6) begin
      tick();
      chk("bp_no_pulse", tx_valid, 1'b0);
      chk("bp_ready1", req_ready[1], 1'b0);
      chk("bp_ready3", req_ready[3], 1'b0);
    end
    tx_ready = 1'b1;
    collect(16);
    chk("bp_count", p_n, 2);
    chk("bp_first", p_id[0], 1);
    chk("bp_second", p_id[1], 3);

    // 5 Wrap: last grant went to 3, now 0 and 3 pending -> 0 first
    load(4'b1001, 32'hC000_0000);
    collect(16);
    chk("wrap_count", p_n, 2);
    chk("wrap_first", p_id[0], 0);
    chk("wrap_second", p_id[1], 3);

    // 2 Single word latency
    repeat (4) tick();
    req_reg[2*RW +: RW] = 32'hDEADBEEF;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("single_t1_no_pulse", tx_valid, 1'b0);
    chk("single_t1_ready2", req_ready[2], 1'b0);
    tick();
    chk("single_pulse", tx_valid, 1'b1);
    chk("single_reg", tx_reg, 32'hDEADBEEF);
    chk("single_id", tx_id, 2'd2);
    chk("single_ready2", req_ready[2], 1'b1);
    tick();
    chk("single_width", tx_valid, 1'b0);

    // 6 Reset during ISSUE
    repeat (6) tick();
    load(4'b0110, 32'hD000_0000);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (tx_valid) found = 1'b1;
      else tick();
    end
    chk("midrst_reached_issue", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 4'b1111);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_tx_id", tx_id, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load(4'b1001, 32'hE000_0000);
    collect(12);
    chk("midrst_count", p_n, 2);
    chk("midrst_first_id", p_id[0], 0);

    // Randomized traffic against the model
    pulses = 0;
    repeat (3000) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_reg[i*RW +: RW] = $urandom;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (tx_valid) pulses++;
    end
    req_valid = '0;
    tx_ready = 1'b1;
    repeat (30) tick();
    chk("rand_activity", (pulses > 100), 1'b1);
    chk("rand_drained", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
